// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and helpers
// for deriving bit timing from clock and baud parameters.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Rounded to nearest so that the realised baud rate error is minimised.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int frame_bits(input int parity, input int stop_bits);
        return 1 + 8 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last clock of every bit period while
// enabled; clear restarts the period so bit edges align to a request.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, with a txStart/txBusy handshake upstream.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY > PARITY_ODD || PARITY < PARITY_NONE) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    uart_state_t state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic        parity_bit;
    logic        tick;
    logic        accept;

    assign accept = (state == ST_IDLE) && txStart;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .enable(state != ST_IDLE),
        .tick  (tick)
    );

    // tx is always loaded one state ahead so it only moves on bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            txBusy     <= 1'b0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (txStart) begin
                        shift_reg  <= txData;
                        parity_bit <= (PARITY == PARITY_ODD) ? ~^txData : ^txData;
                        bit_idx    <= '0;
                        tx         <= 1'b0;
                        txBusy     <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx      <= 1'b1;
                        bit_idx <= '0;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_idx == 3'(STOP_BITS - 1)) begin
                            tx     <= 1'b1;
                            txBusy <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    tx     <= 1'b1;
                    txBusy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four serializer instances (no parity, even, odd, two stop
// bits) share one stimulus stream at 4 clocks per bit.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic [3:0] tx_v;
    logic [3:0] busy_v;

    int errors = 0;
    int checks = 0;

    logic tx_log   [4][128];
    logic busy_log [4][128];

    localparam int PAR_CFG  [4] = '{0, 1, 2, 0};
    localparam int STOP_CFG [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_FREQ(40), .BAUD(10), .PARITY(0), .STOP_BITS(1)) dut_none (
        .clk(clk), .reset(reset), .txStart(txStart), .txData(txData), .txBusy(busy_v[0]), .tx(tx_v[0]));
    uart_tx_serializer #(.CLK_FREQ(40), .BAUD(10), .PARITY(1), .STOP_BITS(1)) dut_even (
        .clk(clk), .reset(reset), .txStart(txStart), .txData(txData), .txBusy(busy_v[1]), .tx(tx_v[1]));
    uart_tx_serializer #(.CLK_FREQ(40), .BAUD(10), .PARITY(2), .STOP_BITS(1)) dut_odd (
        .clk(clk), .reset(reset), .txStart(txStart), .txData(txData), .txBusy(busy_v[2]), .tx(tx_v[2]));
    uart_tx_serializer #(.CLK_FREQ(40), .BAUD(10), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .reset(reset), .txStart(txStart), .txData(txData), .txBusy(busy_v[3]), .tx(tx_v[3]));

    // Sample j (1-based) is the line value in the j-th cycle after acceptance.
    function automatic logic exp_tx(input logic [7:0] data, input int par, input int stop, input int j);
        int b;
        if (j < 1 || j > frame_bits(par, stop) * 4) return 1'b1;
        b = (j - 1) / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (par != 0 && b == 9) return (par == 1) ? ^data : ~^data;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int par, input int stop, input int j);
        return (j >= 1 && j <= frame_bits(par, stop) * 4);
    endfunction

    task automatic log_sample(input int k);
        for (int d = 0; d < 4; d++) begin
            tx_log[d][k]   = tx_v[d];
            busy_log[d][k] = busy_v[d];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        txStart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_and_log(input logic [7:0] data, input int n);
        txData = data;
        txStart = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            log_sample(k);
            if (k == 1) txStart = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (tx_v !== 4'hF || busy_v !== 4'h0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: tx=%b busy=%b, need tx=1111 busy=0000", k, tx_v, busy_v);
            end
        end
    endtask

    task automatic check_frame(input int d, input logic [7:0] data, input string name);
        int busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (busy_log[d][k] === 1'b1) busy_cnt++;
            checks++;
            if (tx_log[d][k] !== exp_tx(data, PAR_CFG[d], STOP_CFG[d], k) ||
                busy_log[d][k] !== exp_busy(PAR_CFG[d], STOP_CFG[d], k)) begin
                errors++;
                $display("[TB] FAIL %s sample %0d: tx=%b busy=%b, need tx=%b busy=%b", name, k,
                         tx_log[d][k], busy_log[d][k], exp_tx(data, PAR_CFG[d], STOP_CFG[d], k),
                         exp_busy(PAR_CFG[d], STOP_CFG[d], k));
            end
        end
        checks++;
        if (busy_cnt != frame_bits(PAR_CFG[d], STOP_CFG[d]) * 4) begin
            errors++;
            $display("[TB] FAIL %s busy_len: got %0d cycles, need %0d", name, busy_cnt,
                     frame_bits(PAR_CFG[d], STOP_CFG[d]) * 4);
        end
    endtask

    task automatic test_frame_basic();
        do_reset();
        send_and_log(8'h41, 60);
        check_frame(0, 8'h41, "basic_0x41");
    endtask

    task automatic test_parity();
        do_reset();
        send_and_log(8'h41, 60);
        check_frame(1, 8'h41, "parity_even");
        check_frame(2, 8'h41, "parity_odd");
        checks++;
        if (tx_log[1][37] !== 1'b0 || tx_log[2][37] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_bit: even=%b odd=%b, need even=0 odd=1", tx_log[1][37], tx_log[2][37]);
        end
    endtask

    task automatic test_stop_bits();
        do_reset();
        send_and_log(8'hFF, 60);
        check_frame(3, 8'hFF, "stop2_0xFF");
    endtask

    task automatic test_busy_ignore();
        do_reset();
        txData = 8'h41;
        txStart = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            log_sample(k);
            if (k == 1) txStart = 1'b0;
            if (k == 10) begin
                txStart = 1'b1;
                txData = 8'h42;
            end
            if (k == 11) txStart = 1'b0;
        end
        check_frame(0, 8'h41, "busy_ignore");
    endtask

    task automatic test_back_to_back();
        logic et;
        logic eb;
        do_reset();
        txData = 8'h41;
        txStart = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (k <= 40) begin
                et = exp_tx(8'h41, 0, 1, k);
                eb = exp_busy(0, 1, k);
            end else begin
                et = exp_tx(8'h42, 0, 1, k - 41);
                eb = exp_busy(0, 1, k - 41);
            end
            checks++;
            if (tx_v[0] !== et || busy_v[0] !== eb) begin
                errors++;
                $display("[TB] FAIL back_to_back sample %0d: tx=%b busy=%b, need tx=%b busy=%b",
                         k, tx_v[0], busy_v[0], et, eb);
            end
            if (k == 1) txData = 8'h42;
            if (k == 42) txStart = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        txData = 8'h41;
        txStart = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) txStart = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_v !== 4'hF || busy_v !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_midframe: tx=%b busy=%b, need tx=1111 busy=0000", tx_v, busy_v);
        end
        // Request arriving together with reset must be dropped.
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_v !== 4'hF || busy_v !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_priority: tx=%b busy=%b, need tx=1111 busy=0000", tx_v, busy_v);
        end
        send_and_log(8'h55, 60);
        check_frame(0, 8'h55, "after_reset_0x55");
        check_frame(3, 8'h55, "after_reset_stop2");
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_parity();
        test_stop_bits();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
